// File: rtl/mux_2to1_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the two-requester round-robin arbiter.
//   arb_state_t       : arbiter FSM states (IDLE = no grant, GRANT = owned)
//   OWNER0 / OWNER1   : owner encodings, equal to grant_o[1] of the owner
//   MAX_BURST_DEFAULT : default number of beats an owner may move per grant
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;

    localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mux_2to1_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_arb_if
// Bundles the two producer handshakes, the grant/select status and the
// single downstream valid/ready port of the arbiter.
//   req0_i/data0_i/ready0_o : requester 0 beat handshake
//   req1_i/data1_i/ready1_o : requester 1 beat handshake
//   grant_o, sel_o          : registered one-hot grant and derived mux select
//   out_valid_o/out_data_o/out_ready_i : downstream beat handshake
// slave  : the arbiter's view
// master : the surrounding system's view (producers + consumer)
// ---------------------------------------------------------------------------
interface mux_arb_if #(
    parameter int DATA_W = 8
);
    logic              req0_i;
    logic [DATA_W-1:0] data0_i;
    logic              ready0_o;
    logic              req1_i;
    logic [DATA_W-1:0] data1_i;
    logic              ready1_o;
    logic [1:0]        grant_o;
    logic              sel_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;

    modport slave (
        input  req0_i, data0_i, req1_i, data1_i, out_ready_i,
        output ready0_o, ready1_o, grant_o, sel_o, out_valid_o, out_data_o
    );

    modport master (
        output req0_i, data0_i, req1_i, data1_i, out_ready_i,
        input  ready0_o, ready1_o, grant_o, sel_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/mux_2to1_arbiter_mux.sv
// ---------------------------------------------------------------------------
// mux_2to1
// Plain 2:1 data selector used as the shared datapath of the arbiter.
//   sel_i : 0 selects x1_i, 1 selects x2_i
//   x1_i  : input 0 data
//   x2_i  : input 1 data
//   y_o   : selected data
// ---------------------------------------------------------------------------
module mux_2to1 #(
    parameter int DATA_W = 8
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] x1_i,
    input  logic [DATA_W-1:0] x2_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = sel_i ? x2_i : x1_i;

endmodule

// File: rtl/mux_2to1_arbiter.sv
// ---------------------------------------------------------------------------
// mux_2to1_arbiter
// Round-robin arbiter that shares one 2:1 mux between two valid/ready
// requesters and registers the selected beat into a one-entry output stage.
// An owner may move up to MAX_BURST beats per grant before yielding to a
// waiting requester; with nobody waiting it simply keeps the grant.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : mux_arb_if slave port (requesters, grant/sel, output stage)
// ---------------------------------------------------------------------------
module mux_2to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    mux_arb_if.slave  bus
);

    localparam int                 CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              lastOwner_q, lastOwner_d;
    logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;
    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q, outData_d;

    logic              owner;
    logic              slotFree;
    logic              ready0, ready1;
    logic              transfer;
    logic              ownerReq, otherReq;
    logic [CNT_W-1:0]  cntInc;
    logic [DATA_W-1:0] muxY;

    // Handshake qualifiers are built only from registered grant and the
    // output stage, so there is no combinational path from req to ready.
    assign owner    = grant_q[1];
    assign slotFree = !outValid_q || bus.out_ready_i;
    assign ready0   = grant_q[0] && slotFree;
    assign ready1   = grant_q[1] && slotFree;
    assign transfer = (bus.req0_i && ready0) || (bus.req1_i && ready1);
    assign ownerReq = (owner == OWNER1) ? bus.req1_i : bus.req0_i;
    assign otherReq = (owner == OWNER1) ? bus.req0_i : bus.req1_i;
    assign cntInc   = beatCnt_q + 1'b1;

    mux_2to1 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel_i (grant_q[1]),
        .x1_i  (bus.data0_i),
        .x2_i  (bus.data1_i),
        .y_o   (muxY)
    );

    // Arbiter next state. From IDLE a lone request wins outright and a tie
    // goes to whoever did not own the mux last. In GRANT the owner yields
    // when it stops requesting, or when its burst quota is used up and the
    // other side is waiting; an uncontested owner just restarts its quota.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastOwner_d = lastOwner_q;
        beatCnt_d   = beatCnt_q;
        case (state_q)
            IDLE: begin
                beatCnt_d = '0;
                if (bus.req0_i && bus.req1_i) begin
                    state_d = GRANT;
                    grant_d = (lastOwner_q == OWNER1) ? 2'b01 : 2'b10;
                end else if (bus.req0_i) begin
                    state_d = GRANT;
                    grant_d = 2'b01;
                end else if (bus.req1_i) begin
                    state_d = GRANT;
                    grant_d = 2'b10;
                end
            end
            GRANT: begin
                if (!ownerReq) begin
                    state_d     = IDLE;
                    grant_d     = 2'b00;
                    lastOwner_d = owner;
                    beatCnt_d   = '0;
                end else if (transfer) begin
                    if (cntInc == BURST_MAX) begin
                        beatCnt_d = '0;
                        if (otherReq) begin
                            state_d     = IDLE;
                            grant_d     = 2'b00;
                            lastOwner_d = owner;
                        end
                    end else begin
                        beatCnt_d = cntInc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Single-entry output stage: a new beat always wins (covers load and
    // drain in the same cycle); otherwise a consumer pop empties it.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        if (transfer) begin
            outValid_d = 1'b1;
            outData_d  = muxY;
        end else if (bus.out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    // State registers. Reset drops any in-flight beat and biases the first
    // tie toward requester 0 by pretending requester 1 owned the mux last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            lastOwner_q <= OWNER1;
            beatCnt_q   <= '0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastOwner_q <= lastOwner_d;
            beatCnt_q   <= beatCnt_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
        end
    end

    assign bus.ready0_o    = ready0;
    assign bus.ready1_o    = ready1;
    assign bus.grant_o     = grant_q;
    assign bus.sel_o       = grant_q[1];
    assign bus.out_valid_o = outValid_q;
    assign bus.out_data_o  = outData_q;

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_2to1_arbiter
// Drives the arbiter with directed and randomized requester/consumer
// traffic and compares every cycle against a behavioural model that tracks
// the current owner, burst usage and output stage as plain integers.
// ---------------------------------------------------------------------------
module tb_mux_2to1_arbiter;

    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mux_arb_if #(.DATA_W(DW)) bus ();

    mux_2to1_arbiter #(
        .DATA_W    (DW),
        .MAX_BURST (MAXB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Stimulus knobs: per-requester request probability and beat budget.
    int       pct0 = 0, pct1 = 0, pctReady = 100;
    int       budget0 = 0, budget1 = 0;
    bit       randData = 1'b0;
    bit       resetNow = 1'b1;
    bit       pend0 = 1'b0, pend1 = 1'b0;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00, next0 = 8'h00, next1 = 8'h00;
    logic     outReady = 1'b1;

    // Reference model: owner is -1 when nobody holds the mux.
    int       mOwner = -1, mLast = 1, mBeats = 0;
    bit       mValid = 1'b0;
    logic [7:0] mData = 8'h00;
    bit       modelKnown = 1'b0;

    logic [7:0] seen[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h",
                     tag, cycle, actual, expected);
        end
    endtask

    // Each iteration starts on a falling edge: drive inputs, compare the
    // DUT against the model, advance the model across the next rising edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            bit         slotFree, r0y, r1y, acc, ownReq, othReq;
            int         accOwner;
            logic [7:0] accData;
            logic [1:0] expGrant;

            if (!pend0 && budget0 > 0 && $urandom_range(99) < pct0) begin
                pend0 = 1'b1;
                if (randData) dat0 = 8'($urandom);
                else begin dat0 = next0; next0 = next0 + 8'd1; end
            end
            if (!pend1 && budget1 > 0 && $urandom_range(99) < pct1) begin
                pend1 = 1'b1;
                if (randData) dat1 = 8'($urandom);
                else begin dat1 = next1; next1 = next1 + 8'd1; end
            end
            outReady = ($urandom_range(99) < pctReady);

            reset           = resetNow;
            bus.req0_i      = pend0;
            bus.data0_i     = dat0;
            bus.req1_i      = pend1;
            bus.data1_i     = dat1;
            bus.out_ready_i = outReady;
            #1;

            expGrant = (mOwner == 0) ? 2'b01 : (mOwner == 1) ? 2'b10 : 2'b00;
            slotFree = !mValid || outReady;
            r0y      = (mOwner == 0) && slotFree;
            r1y      = (mOwner == 1) && slotFree;

            if (modelKnown) begin
                checkOutput("grant",     bus.grant_o,     expGrant);
                checkOutput("sel",       bus.sel_o,       (mOwner == 1));
                checkOutput("ready0",    bus.ready0_o,    r0y);
                checkOutput("ready1",    bus.ready1_o,    r1y);
                checkOutput("out_valid", bus.out_valid_o, mValid);
                checkOutput("out_data",  bus.out_data_o,  mData);
            end
            if (bus.out_valid_o && outReady) seen.push_back(bus.out_data_o);

            if (resetNow) begin
                mOwner = -1; mLast = 1; mBeats = 0;
                mValid = 1'b0; mData = 8'h00;
                modelKnown = 1'b1;
            end else begin
                acc      = (r0y && pend0) || (r1y && pend1);
                accOwner = mOwner;
                accData  = (mOwner == 1) ? dat1 : dat0;
                if (acc) begin
                    mValid = 1'b1;
                    mData  = accData;
                end else if (outReady) begin
                    mValid = 1'b0;
                end
                if (mOwner < 0) begin
                    if (pend0 && pend1) mOwner = 1 - mLast;
                    else if (pend0)     mOwner = 0;
                    else if (pend1)     mOwner = 1;
                    mBeats = 0;
                end else begin
                    ownReq = (mOwner == 0) ? pend0 : pend1;
                    othReq = (mOwner == 0) ? pend1 : pend0;
                    if (!ownReq) begin
                        mLast  = mOwner;
                        mOwner = -1;
                        mBeats = 0;
                    end else if (acc) begin
                        mBeats++;
                        if (mBeats == MAXB) begin
                            mBeats = 0;
                            if (othReq) begin
                                mLast  = mOwner;
                                mOwner = -1;
                            end
                        end
                    end
                end
                if (acc && accOwner == 0) begin pend0 = 1'b0; budget0--; end
                if (acc && accOwner == 1) begin pend1 = 1'b0; budget1--; end
            end

            @(negedge clk);
            cycle++;
        end
    endtask

    initial begin
        @(negedge clk);

        // Reset held with both requesters pending; requester 0 must win.
        pend0 = 1'b1; dat0 = 8'h3C;
        pend1 = 1'b1; dat1 = 8'hA5;
        resetNow = 1'b1;
        applyStimulus(3);
        resetNow = 1'b0;
        applyStimulus(1);
        #1 checkOutput("rst_release_grant", bus.grant_o, 2'b01);
        applyStimulus(1);
        #1;
        checkOutput("first_beat_valid", bus.out_valid_o, 1'b1);
        checkOutput("first_beat_data",  bus.out_data_o,  8'h3C);
        applyStimulus(8);

        // Requester 1 streams 0x10..0x17 alone.
        seen.delete();
        next1 = 8'h10; budget1 = 8; pct1 = 100;
        applyStimulus(14);
        checkOutput("stream_count", seen.size(), 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("stream_beat%0d", i),
                        (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF,
                        32'h10 + i);

        // Both requesting continuously: alternating bursts of MAXB.
        seen.delete();
        next0 = 8'h40; next1 = 8'h80;
        budget0 = 1000; budget1 = 1000; pct0 = 100; pct1 = 100;
        applyStimulus(24);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("alt_beat%0d", i),
                        (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF,
                        (((i / MAXB) % 2 == 0) ? 32'h40 : 32'h80)
                            + (i / (2 * MAXB)) * MAXB + (i % MAXB));

        // Consumer stalls for three cycles mid-burst.
        applyStimulus(2);
        pctReady = 0;
        applyStimulus(3);
        pctReady = 100;
        applyStimulus(10);

        // Drain, then owner 0 gives up after two beats with 1 waiting.
        budget0 = 0; budget1 = 0;
        applyStimulus(14);
        budget0 = 2; pct0 = 100; pct1 = 0;
        applyStimulus(2);
        budget1 = 3; pct1 = 100;
        applyStimulus(10);

        // Reset in the middle of contended traffic.
        budget0 = 1000; budget1 = 1000;
        applyStimulus(7);
        resetNow = 1'b1;
        applyStimulus(1);
        #1;
        checkOutput("midrst_valid", bus.out_valid_o, 1'b0);
        checkOutput("midrst_grant", bus.grant_o, 2'b00);
        resetNow = 1'b0;
        applyStimulus(1);
        #1 checkOutput("midrst_tie_grant", bus.grant_o, 2'b01);

        // Randomized traffic with occasional resets.
        randData = 1'b1;
        pct0 = 55; pct1 = 55; pctReady = 70;
        budget0 = 100000; budget1 = 100000;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(40);
            resetNow = (k % 4 == 3);
            applyStimulus(1);
            resetNow = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
